// File: rtl/wv_pkg.sv
// Shared types and constants for the program-and-verify sequencer that sits
// upstream of mac_level.
package wv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_GAP,
        RD,
        CHECK,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        ST_PASS            = 2'b00,
        ST_RETRY_EXHAUSTED = 2'b01,
        ST_OVERSHOOT       = 2'b10,
        ST_TIMEOUT         = 2'b11
    } status_e;

    localparam logic WRITE_MODE = 1'b0;
    localparam logic READ_MODE  = 1'b1;
    localparam logic OP_SET     = 1'b1;
    localparam logic OP_RESET   = 1'b0;

    // Next word-line code: add the step in 9 bits so a wrap can never slip under the ceiling.
    function automatic logic [7:0] step_vwl(input logic [7:0] v,
                                            input logic [7:0] step,
                                            input logic [7:0] vmax);
        logic [8:0] sum;
        sum = {1'b0, v} + {1'b0, step};
        return (sum > {1'b0, vmax}) ? vmax : sum[7:0];
    endfunction

endpackage

// File: rtl/write_verify_ctrl_if.sv
// Command, response and mac_level-facing signals of write_verify_ctrl.
// slave = the controller, master = the host / mac_level side.
interface write_verify_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_addr;
    logic       cmd_op;
    logic [7:0] cmd_target;

    logic       work_en;
    logic       op_mode;
    logic       work_mode;
    logic [9:0] addr_in;
    logic [7:0] v_wl;
    logic       work_down;
    logic [7:0] i_read;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_status;
    logic [3:0] rsp_tries;
    logic [7:0] rsp_iread;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_op, cmd_target,
        input  work_down, i_read, rsp_ready,
        output cmd_ready, work_en, op_mode, work_mode, addr_in, v_wl,
        output rsp_valid, rsp_status, rsp_tries, rsp_iread
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_op, cmd_target,
        output work_down, i_read, rsp_ready,
        input  cmd_ready, work_en, op_mode, work_mode, addr_in, v_wl,
        input  rsp_valid, rsp_status, rsp_tries, rsp_iread
    );

endinterface

// File: rtl/wv_compare.sv
// Verify classifier: signed read error against target, tolerance window and
// direction-aware overshoot detection.
module wv_compare
    import wv_pkg::*;
#(
    parameter logic [7:0] TOL = 8'd4
) (
    input  logic [7:0] i_read,
    input  logic [7:0] target,
    input  logic       op,
    output logic       within_tol,
    output logic       overshoot
);

    logic signed [8:0] diff;
    logic signed [8:0] tol_s;

    assign diff  = $signed({1'b0, i_read}) - $signed({1'b0, target});
    assign tol_s = $signed({1'b0, TOL});

    assign within_tol = (diff <= tol_s) && (diff >= -tol_s);

    // A set pulse can only push current up, a reset pulse only down; passing
    // the window in the driven direction cannot be undone by more pulses.
    assign overshoot = ((op == OP_SET)   && (diff >  tol_s)) ||
                       ((op == OP_RESET) && (diff < -tol_s));

endmodule

// File: rtl/write_verify_ctrl.sv
// Command-level program-and-verify sequencer: alternates write and read
// operations on mac_level, stepping v_wl until the read current is in tolerance.
module write_verify_ctrl
    import wv_pkg::*;
#(
    parameter logic [7:0] V_START   = 8'h40,
    parameter logic [7:0] V_STEP    = 8'h08,
    parameter logic [7:0] V_MAX     = 8'hF0,
    parameter logic [7:0] TOL       = 8'd4,
    parameter int         MAX_TRIES = 8,
    parameter int         TIMEOUT   = 1023
) (
    input logic                sys_clk,
    input logic                sys_rst_n,
    write_verify_ctrl_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state;
    logic [9:0]    addr_q;
    logic          op_q;
    logic [7:0]    target_q;
    logic [3:0]    tries;
    logic [CW-1:0] tmo_cnt;
    logic          work_en_q;
    logic          work_mode_q;
    logic [7:0]    v_wl_q;
    status_e       status_q;
    logic [7:0]    iread_q;

    logic          within_tol;
    logic          overshoot;
    logic          tmo_hit;

    wv_compare #(.TOL(TOL)) u_cmp (
        .i_read     (iread_q),
        .target     (target_q),
        .op         (op_q),
        .within_tol (within_tol),
        .overshoot  (overshoot)
    );

    // Counter holds cycles already spent in WR/RD, so work_en is high for
    // exactly TIMEOUT cycles before the abort.
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            op_q        <= 1'b0;
            target_q    <= '0;
            tries       <= '0;
            tmo_cnt     <= '0;
            work_en_q   <= 1'b0;
            work_mode_q <= WRITE_MODE;
            v_wl_q      <= V_START;
            status_q    <= ST_PASS;
            iread_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_q      <= bus.cmd_addr;
                        op_q        <= bus.cmd_op;
                        target_q    <= bus.cmd_target;
                        v_wl_q      <= V_START;
                        tries       <= '0;
                        iread_q     <= '0;
                        tmo_cnt     <= '0;
                        work_en_q   <= 1'b1;
                        work_mode_q <= WRITE_MODE;
                        state       <= WR;
                    end
                end

                WR: begin
                    if (bus.work_down) begin
                        tries     <= tries + 4'd1;
                        work_en_q <= 1'b0;
                        state     <= WR_GAP;
                    end else if (tmo_hit) begin
                        work_en_q <= 1'b0;
                        status_q  <= ST_TIMEOUT;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                WR_GAP: begin
                    work_en_q   <= 1'b1;
                    work_mode_q <= READ_MODE;
                    tmo_cnt     <= '0;
                    state       <= RD;
                end

                RD: begin
                    if (bus.work_down) begin
                        iread_q   <= bus.i_read;
                        work_en_q <= 1'b0;
                        state     <= CHECK;
                    end else if (tmo_hit) begin
                        work_en_q <= 1'b0;
                        status_q  <= ST_TIMEOUT;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                // This cycle doubles as the work_en=0 gap before the next write.
                CHECK: begin
                    if (within_tol) begin
                        status_q <= ST_PASS;
                        state    <= RESP;
                    end else if (overshoot) begin
                        status_q <= ST_OVERSHOOT;
                        state    <= RESP;
                    end else if (tries == 4'(MAX_TRIES)) begin
                        status_q <= ST_RETRY_EXHAUSTED;
                        state    <= RESP;
                    end else begin
                        v_wl_q      <= step_vwl(v_wl_q, V_STEP, V_MAX);
                        work_en_q   <= 1'b1;
                        work_mode_q <= WRITE_MODE;
                        tmo_cnt     <= '0;
                        state       <= WR;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.work_en    = work_en_q;
    assign bus.op_mode    = op_q;
    assign bus.work_mode  = work_mode_q;
    assign bus.addr_in    = addr_q;
    assign bus.v_wl       = v_wl_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_status = status_q;
    assign bus.rsp_tries  = tries;
    assign bus.rsp_iread  = iread_q;

endmodule

// File: tb/tb_write_verify_ctrl.sv
// Bench for write_verify_ctrl: two instances (V_START 0x40 and 0xE0) share one
// stimulus stream; outcomes come from a per-command reference model.
module tb_write_verify_ctrl;

    localparam int TOL       = 4;
    localparam int MAX_TRIES = 8;
    localparam int TIMEOUT   = 1023;
    localparam int V_STEP    = 8;
    localparam int V_MAX     = 240;

    logic sys_clk;
    logic sys_rst_n;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] rd_vals [MAX_TRIES];

    write_verify_ctrl_if bus_a ();
    write_verify_ctrl_if bus_b ();

    assign bus_b.cmd_valid  = bus_a.cmd_valid;
    assign bus_b.cmd_addr   = bus_a.cmd_addr;
    assign bus_b.cmd_op     = bus_a.cmd_op;
    assign bus_b.cmd_target = bus_a.cmd_target;
    assign bus_b.work_down  = bus_a.work_down;
    assign bus_b.i_read     = bus_a.i_read;
    assign bus_b.rsp_ready  = bus_a.rsp_ready;

    write_verify_ctrl dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_a)
    );

    write_verify_ctrl #(.V_START(8'hE0)) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-line code of the k-th write pulse.
    function automatic logic [7:0] vexp(input int start, input int k);
        int v;
        v = start + V_STEP * k;
        return (v > V_MAX) ? 8'(V_MAX) : 8'(v);
    endfunction

    // Called at the negedge where an operation is first visible.
    task automatic do_phase(input logic mode, input logic [7:0] va, input logic [7:0] vb,
                            input logic op, input logic [9:0] addr, input int lat,
                            input logic [7:0] rd);
        chk("work_en",        bus_a.work_en, 1);
        chk("work_en_b",      bus_b.work_en, 1);
        chk("work_mode",      bus_a.work_mode, mode);
        chk("v_wl",           bus_a.v_wl, va);
        chk("v_wl_b",         bus_b.v_wl, vb);
        chk("addr_in",        bus_a.addr_in, addr);
        chk("op_mode",        bus_a.op_mode, op);
        chk("cmd_ready_busy", bus_a.cmd_ready, 0);
        chk("rsp_valid_busy", bus_a.rsp_valid, 0);
        repeat (lat - 1) @(negedge sys_clk);
        chk("work_en_hold", bus_a.work_en, 1);
        bus_a.work_down = 1'b1;
        bus_a.i_read    = mode ? rd : 8'($urandom);
        @(negedge sys_clk);
        chk("work_en_gap",   bus_a.work_en, 0);
        chk("work_en_gap_b", bus_b.work_en, 0);
        // Stray done pulses during the gap/check cycle must be ignored.
        bus_a.work_down = 1'($urandom);
        bus_a.i_read    = 8'($urandom);
        @(negedge sys_clk);
        bus_a.work_down = 1'b0;
    endtask

    // lat = cycles of work_en before work_down; lat 0 = mac_level never answers.
    task automatic run_cmd(input logic op, input logic [9:0] addr, input logic [7:0] tgt,
                           input int lat, input int hold);
        logic [1:0] st;
        int         n_wr;
        logic [7:0] last;
        int         d;
        int         cnt;
        bit         fin;

        st = 2'b01; n_wr = MAX_TRIES; last = 8'd0; fin = 1'b0;
        if (lat == 0) begin
            st = 2'b11; n_wr = 0;
        end else begin
            for (int k = 0; k < MAX_TRIES; k++) begin
                if (!fin) begin
                    d    = int'(rd_vals[k]) - int'(tgt);
                    last = rd_vals[k];
                    if (d >= -TOL && d <= TOL) begin
                        st = 2'b00; n_wr = k + 1; fin = 1'b1;
                    end else if ((op && d > TOL) || (!op && d < -TOL)) begin
                        st = 2'b10; n_wr = k + 1; fin = 1'b1;
                    end
                end
            end
        end

        cnt = 0;
        while (!bus_a.cmd_ready && cnt < 50) begin
            @(negedge sys_clk);
            cnt++;
        end
        chk("cmd_ready_idle", bus_a.cmd_ready, 1);
        bus_a.cmd_valid  = 1'b1;
        bus_a.cmd_op     = op;
        bus_a.cmd_addr   = addr;
        bus_a.cmd_target = tgt;
        @(negedge sys_clk);
        // Keep offering junk commands while busy; none may be taken.
        bus_a.cmd_addr   = 10'($urandom);
        bus_a.cmd_op     = 1'($urandom);
        bus_a.cmd_target = 8'($urandom);

        if (lat == 0) begin
            chk("to_work_en", bus_a.work_en, 1);
            cnt = 0;
            while (bus_a.work_en && cnt < 1100) begin
                cnt++;
                @(negedge sys_clk);
            end
            chk("to_len", cnt, TIMEOUT);
        end else begin
            for (int k = 0; k < n_wr; k++) begin
                do_phase(1'b0, vexp(8'h40, k), vexp(8'hE0, k), op, addr, lat, 8'd0);
                do_phase(1'b1, vexp(8'h40, k), vexp(8'hE0, k), op, addr, lat, rd_vals[k]);
            end
        end
        bus_a.cmd_valid = 1'b0;

        chk("rsp_valid",    bus_a.rsp_valid, 1);
        chk("rsp_status",   bus_a.rsp_status, st);
        chk("rsp_status_b", bus_b.rsp_status, st);
        chk("rsp_tries",    bus_a.rsp_tries, n_wr);
        chk("rsp_iread",    bus_a.rsp_iread, last);
        chk("work_en_resp", bus_a.work_en, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge sys_clk);
            chk("bp_rsp_valid", bus_a.rsp_valid, 1);
            chk("bp_status",    bus_a.rsp_status, st);
            chk("bp_tries",     bus_a.rsp_tries, n_wr);
            chk("bp_iread",     bus_a.rsp_iread, last);
            chk("bp_cmd_ready", bus_a.cmd_ready, 0);
        end
        bus_a.rsp_ready = 1'b1;
        @(negedge sys_clk);
        bus_a.rsp_ready = 1'b0;
        chk("rsp_done_valid", bus_a.rsp_valid, 0);
        chk("rsp_done_ready", bus_a.cmd_ready, 1);
    endtask

    initial begin
        int tgt;
        int r;

        sys_rst_n        = 1'b0;
        bus_a.cmd_valid  = 1'b0;
        bus_a.cmd_addr   = '0;
        bus_a.cmd_op     = 1'b0;
        bus_a.cmd_target = '0;
        bus_a.work_down  = 1'b0;
        bus_a.i_read     = '0;
        bus_a.rsp_ready  = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        chk("rst_cmd_ready", bus_a.cmd_ready, 1);
        chk("rst_work_en",   bus_a.work_en, 0);
        chk("rst_v_wl",      bus_a.v_wl, 8'h40);
        chk("rst_v_wl_b",    bus_b.v_wl, 8'hE0);
        chk("rst_rsp_valid", bus_a.rsp_valid, 0);
        chk("rst_status",    bus_a.rsp_status, 0);
        chk("rst_tries",     bus_a.rsp_tries, 0);
        chk("rst_iread",     bus_a.rsp_iread, 0);
        chk("rst_addr_in",   bus_a.addr_in, 0);
        chk("rst_work_mode", bus_a.work_mode, 0);

        // Immediate pass
        rd_vals[0] = 8'd98;
        run_cmd(1'b1, 10'h006, 8'd100, 3, 0);

        // Stepped pass
        rd_vals[0] = 8'd60; rd_vals[1] = 8'd80; rd_vals[2] = 8'd101;
        run_cmd(1'b1, 10'h155, 8'd100, 2, 1);

        // Retry exhaustion; instance B walks E0, E8, F0, F0...
        for (int k = 0; k < MAX_TRIES; k++) rd_vals[k] = 8'd10;
        run_cmd(1'b1, 10'h3FF, 8'd100, 1, 0);

        // Overshoot on a reset command
        rd_vals[0] = 8'd30;
        run_cmd(1'b0, 10'h0A0, 8'd50, 4, 0);

        // Tolerance edges: -5 on set keeps going, then +4 passes
        rd_vals[0] = 8'd95; rd_vals[1] = 8'd104;
        run_cmd(1'b1, 10'h011, 8'd100, 2, 0);
        // +5 on set is overshoot
        rd_vals[0] = 8'd105;
        run_cmd(1'b1, 10'h012, 8'd100, 1, 0);
        // +5 on reset keeps going, then -4 passes
        rd_vals[0] = 8'd15; rd_vals[1] = 8'd6;
        run_cmd(1'b0, 10'h013, 8'd10, 2, 0);

        // Timeout on the first write
        run_cmd(1'b1, 10'h200, 8'd100, 0, 2);

        // Done arriving in the last allowed cycle is a completion
        rd_vals[0] = 8'd77;
        run_cmd(1'b1, 10'h201, 8'd77, TIMEOUT, 0);

        // Backpressure
        rd_vals[0] = 8'd42;
        run_cmd(1'b0, 10'h0F0, 8'd40, 2, 10);

        // Reset asserted mid-read
        bus_a.cmd_valid  = 1'b1;
        bus_a.cmd_op     = 1'b1;
        bus_a.cmd_addr   = 10'h2A5;
        bus_a.cmd_target = 8'd77;
        @(negedge sys_clk);
        bus_a.cmd_valid = 1'b0;
        do_phase(1'b0, 8'h40, 8'hE0, 1'b1, 10'h2A5, 2, 8'd0);
        chk("mid_rd_en",   bus_a.work_en, 1);
        chk("mid_rd_mode", bus_a.work_mode, 1);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("async_work_en",   bus_a.work_en, 0);
        chk("async_work_en_b", bus_b.work_en, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (4) begin
            @(negedge sys_clk);
            chk("abort_rsp_valid", bus_a.rsp_valid, 0);
            chk("abort_cmd_ready", bus_a.cmd_ready, 1);
            chk("abort_work_en",   bus_a.work_en, 0);
        end
        chk("abort_v_wl", bus_a.v_wl, 8'h40);

        // Randomized commands with read currents scattered around the target
        for (int n = 0; n < 25; n++) begin
            tgt = int'($urandom_range(20, 235));
            for (int k = 0; k < MAX_TRIES; k++) begin
                r = tgt + int'($urandom_range(0, 24)) - 12;
                rd_vals[k] = 8'(r);
            end
            run_cmd(1'($urandom), 10'($urandom), 8'(tgt),
                    int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
